life_gen_scheduler: RTL and testbench

Sequences Game of Life generation updates against the VGA frame timing. It counts frames from the display controller's vertical sync and issues start pulses to the next-generation compute engine. It performs a tear-free ping-pong swap of the cell buffers during vertical sync, and runs a clear sweep over both cell banks. It sits between the display controller, the user buttons/switches and the life engine / cell RAM.

---
 rtl/life_gen_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_life_gen_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler
// Paces Game of Life generations against VGA frame timing. Counts frames
// from vertical sync, starts the next-generation engine, swaps the
// front/back cell banks only while vSync is high (tear-free), and runs a
// zero-fill sweep over both banks on request.
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   vSync        : vertical sync from the display controller (asynchronous)
//   run_sw       : 1 = free-run, 0 = paused
//   step_btn     : single-step request, honoured only while paused in IDLE
//   clear_btn    : clear-grid request
//   speed        : generation period select, period = BASE_FRAMES << speed
//   eng_done     : engine finished writing the back bank (1-cycle pulse)
//   eng_start    : 1-cycle pulse, engine reads front_sel, writes ~front_sel
//   front_sel    : bank shown by the display
//   clr_we       : write zero to both banks at clr_addr
//   clr_addr     : clear sweep address
//   gen_count    : generations completed since the last clear/reset
//   state        : IDLE=0, START=1, BUSY=2, WAIT_VS=3, CLEAR=4
module life_gen_scheduler #(
    parameter int ADDR_W      = 10,
    parameter int GEN_W       = 16,
    parameter int BASE_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vSync,
    input  logic              run_sw,
    input  logic              step_btn,
    input  logic              clear_btn,
    input  logic [1:0]        speed,
    input  logic              eng_done,
    output logic              eng_start,
    output logic              front_sel,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [GEN_W-1:0]  gen_count,
    output logic [2:0]        state
);

    // Frame counter must hold BASE_FRAMES*8-1 (slowest speed).
    localparam int FRM_W = $clog2(BASE_FRAMES * 8);
    localparam logic [FRM_W:0] BASE_V = (FRM_W + 1)'(BASE_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_WAIT_VS = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          sync1_r;
    logic [2:0]          sync2_r;
    logic [2:0]          hist_r;
    logic [2:0]          rise_s;
    logic                vs_rise_s;
    logic                step_rise_s;
    logic                clear_rise_s;
    logic                clear_pend_r;
    logic [FRM_W-1:0]    frm_cnt_r;
    logic [FRM_W:0]      period_s;
    logic [FRM_W:0]      period_m1_s;
    logic                frm_done_s;
    logic                clr_last_s;
    logic                swap_s;
    logic                eng_start_r;
    logic                front_sel_r;
    logic                clr_we_r;
    logic [ADDR_W-1:0]   clr_addr_r;
    logic [GEN_W-1:0]    gen_count_r;

    // Bit 0 = vSync, bit 1 = step_btn, bit 2 = clear_btn.
    assign rise_s       = sync2_r & ~hist_r;
    assign vs_rise_s    = rise_s[0];
    assign step_rise_s  = rise_s[1];
    assign clear_rise_s = rise_s[2];

    // ">=" rather than "==" so a speed decrease takes effect at the next frame.
    assign period_s    = BASE_V << speed;
    assign period_m1_s = period_s - 1'b1;
    assign frm_done_s  = ({1'b0, frm_cnt_r} >= period_m1_s);
    assign clr_last_s  = (clr_addr_r == {ADDR_W{1'b1}});
    assign swap_s      = (state_r == ST_WAIT_VS) && vs_rise_s;

    // Two-flop synchronizers plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            hist_r  <= 3'b000;
        end else begin
            sync1_r <= {clear_btn, step_btn, vSync};
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Next-state logic; a pending clear outranks stepping and free-run.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_pend_r || clear_rise_s) begin
                    state_next_s = ST_CLEAR;
                end else if (!run_sw && step_rise_s) begin
                    state_next_s = ST_START;
                end else if (run_sw && vs_rise_s && frm_done_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: state_next_s = ST_BUSY;
            ST_BUSY: begin
                if (eng_done) begin
                    state_next_s = ST_WAIT_VS;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_VS;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            eng_start_r <= 1'b0;
            clr_we_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            eng_start_r <= (state_next_s == ST_START);
            clr_we_r    <= (state_next_s == ST_CLEAR);
        end
    end

    // Clear request latch: a request during CLEAR schedules another sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_pend_r <= 1'b0;
        end else if ((state_next_s == ST_CLEAR) && (state_r != ST_CLEAR)) begin
            clear_pend_r <= 1'b0;
        end else if (clear_rise_s) begin
            clear_pend_r <= 1'b1;
        end
    end

    // Frame counter: advances only in IDLE while free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!run_sw) begin
                        frm_cnt_r <= '0;
                    end else if (vs_rise_s) begin
                        frm_cnt_r <= frm_done_s ? '0 : frm_cnt_r + 1'b1;
                    end
                end
                ST_WAIT_VS: if (vs_rise_s) frm_cnt_r <= '0;
                ST_CLEAR:   if (clr_last_s) frm_cnt_r <= '0;
                default:    frm_cnt_r <= frm_cnt_r;
            endcase
        end
    end

    // Bank swap, generation count and clear sweep address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel_r <= 1'b0;
            gen_count_r <= '0;
            clr_addr_r  <= '0;
        end else begin
            if (swap_s) begin
                front_sel_r <= ~front_sel_r;
                gen_count_r <= gen_count_r + 1'b1;
            end else if ((state_r == ST_CLEAR) && clr_last_s) begin
                gen_count_r <= '0;
            end
            if (state_r == ST_CLEAR) begin
                clr_addr_r <= clr_last_s ? '0 : clr_addr_r + 1'b1;
            end else begin
                clr_addr_r <= '0;
            end
        end
    end

    assign eng_start = eng_start_r;
    assign front_sel = front_sel_r;
    assign clr_we    = clr_we_r;
    assign clr_addr  = clr_addr_r;
    assign gen_count = gen_count_r;
    assign state     = state_r;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler. A second instance with a 3-bit
// generation counter, fed the same inputs, exercises counter wrap-around.
`timescale 1ns/1ps
module tb_life_gen_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vSync = 1'b0;
    logic       run_sw = 1'b0;
    logic       step_btn = 1'b0;
    logic       clear_btn = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       eng_done = 1'b0;

    logic        eng_start, front_sel, clr_we;
    logic [9:0]  clr_addr;
    logic [15:0] gen_count;
    logic [2:0]  state;

    logic        w_eng_start, w_front_sel, w_clr_we;
    logic [9:0]  w_clr_addr;
    logic [2:0]  w_gen_count;
    logic [2:0]  w_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int eng_delay = 50;

    life_gen_scheduler dut (
        .clk(clk), .rst_n(rst_n), .vSync(vSync), .run_sw(run_sw),
        .step_btn(step_btn), .clear_btn(clear_btn), .speed(speed),
        .eng_done(eng_done), .eng_start(eng_start), .front_sel(front_sel),
        .clr_we(clr_we), .clr_addr(clr_addr), .gen_count(gen_count),
        .state(state)
    );

    life_gen_scheduler #(.GEN_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .vSync(vSync), .run_sw(run_sw),
        .step_btn(step_btn), .clear_btn(clear_btn), .speed(speed),
        .eng_done(eng_done), .eng_start(w_eng_start), .front_sel(w_front_sel),
        .clr_we(w_clr_we), .clr_addr(w_clr_addr), .gen_count(w_gen_count),
        .state(w_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_pulse();
        vSync = 1'b1; ticks(4);
        vSync = 1'b0; ticks(4);
    endtask

    task automatic step_pulse();
        step_btn = 1'b1; ticks(4);
        step_btn = 1'b0; ticks(4);
    endtask

    task automatic clear_pulse();
        clear_btn = 1'b1; ticks(4);
        clear_btn = 1'b0; ticks(4);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int max);
        int n;
        n = 0;
        while (state !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, state, s);
    endtask

    // Engine model: answers each eng_start with eng_done after eng_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                start_cnt++;
                @(negedge clk);
                chk("eng_start_one_cycle", eng_start, 0);
                chk("busy_after_start", state, 2);
                repeat (eng_delay - 1) @(negedge clk);
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    initial begin
        int bad;
        int n;

        // Reset state
        ticks(3);
        chk("rst_state", state, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_front_sel", front_sel, 0);
        chk("rst_clr_we", clr_we, 0);
        chk("rst_clr_addr", clr_addr, 0);
        chk("rst_gen_count", gen_count, 0);
        rst_n = 1'b1;
        ticks(5);
        vs_pulse();
        chk("paused_no_start", start_cnt, 0);

        // Free-run, speed 0: START on the 8th vs_rise counted in IDLE
        run_sw = 1'b1;
        repeat (7) vs_pulse();
        chk("fr1_no_start_7", start_cnt, 0);
        chk("fr1_idle_7", state, 0);
        vs_pulse();
        chk("fr1_start_8", start_cnt, 1);
        chk("fr1_front_before", front_sel, 0);
        wait_state("fr1_wait_vs", 3'd3, 200);
        chk("fr1_gen_before_swap", gen_count, 0);
        vs_pulse();
        chk("fr1_front_swap", front_sel, 1);
        chk("fr1_gen", gen_count, 1);
        chk("fr1_idle", state, 0);
        repeat (7) vs_pulse();
        chk("fr2_no_start_7", start_cnt, 1);
        vs_pulse();
        chk("fr2_start_8", start_cnt, 2);
        wait_state("fr2_wait_vs", 3'd3, 200);
        vs_pulse();
        chk("fr2_front_swap", front_sel, 0);
        chk("fr2_gen", gen_count, 2);

        // Speed 3 for 20 frames, then speed 0 starts on the next vs_rise
        speed = 2'd3;
        repeat (20) vs_pulse();
        chk("spd3_no_start", start_cnt, 2);
        speed = 2'd0;
        vs_pulse();
        chk("spd0_immediate_start", start_cnt, 3);
        wait_state("spd_wait_vs", 3'd3, 200);
        vs_pulse();
        chk("spd_gen", gen_count, 3);
        chk("spd_front", front_sel, 1);
        run_sw = 1'b0;
        ticks(4);

        // Paused single-step; a second step during BUSY is dropped
        step_pulse();
        chk("step_start", start_cnt, 4);
        chk("step_busy", state, 2);
        step_pulse();
        chk("step_ignored_busy", start_cnt, 4);
        wait_state("step_wait_vs", 3'd3, 200);
        vs_pulse();
        chk("step_gen", gen_count, 4);
        chk("step_front", front_sel, 0);
        ticks(20);
        chk("step_no_extra", start_cnt, 4);
        chk("step_idle", state, 0);

        // Clear during BUSY waits for the swap, then sweeps all addresses
        step_pulse();
        chk("clr_step_start", start_cnt, 5);
        clear_pulse();
        chk("clr_still_busy", state, 2);
        wait_state("clr_wait_vs", 3'd3, 200);
        vSync = 1'b1;
        n = 0;
        while (state === 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("clr_swap_idle", state, 0);
        chk("clr_swap_gen", gen_count, 5);
        chk("clr_swap_front", front_sel, 1);
        @(negedge clk);
        chk("clr_enter", state, 4);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (clr_we !== 1'b1 || clr_addr !== 10'(i)) bad++;
            @(negedge clk);
        end
        chk("clr_sweep_bad_cycles", bad, 0);
        chk("clr_done_idle", state, 0);
        chk("clr_done_we", clr_we, 0);
        chk("clr_done_addr", clr_addr, 0);
        chk("clr_done_gen", gen_count, 0);
        chk("clr_front_kept", front_sel, 1);
        vSync = 1'b0;
        ticks(4);

        // Generation counter wrap on the 3-bit instance
        eng_delay = 3;
        for (int g = 1; g <= 8; g++) begin
            step_pulse();
            wait_state("wrap_wait_vs", 3'd3, 60);
            vs_pulse();
            if (g == 7) begin
                chk("wrap_pre_main", gen_count, 7);
                chk("wrap_pre_small", w_gen_count, 7);
            end
        end
        chk("wrap_main", gen_count, 8);
        chk("wrap_small", w_gen_count, 0);

        // Asynchronous reset in the middle of a clear sweep
        clear_pulse();
        n = 0;
        while (clr_addr !== 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_clr_addr", clr_addr, 300);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_clr_we", clr_we, 0);
        chk("arst_clr_addr", clr_addr, 0);
        chk("arst_gen", gen_count, 0);
        chk("arst_front", front_sel, 0);
        chk("arst_eng_start", eng_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(20);
        chk("post_rst_no_we", clr_we, 0);
        chk("post_rst_idle", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
